pipe_ctrl: RTL and testbench

Central pipeline controller for the dual-issue core. It collects per-stage stall requests, exception and branch-mispredict events, and drives the 7-bit stall vector and the flush/flush_cause/new_pc redirect consumed by every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC unit. A small FSM holds an exception flush until any outstanding data-memory access completes. Saturating performance counters track stall and flush cycles.

---
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector, exception/mispredict redirect, and
// saturating stall/flush performance counters.
//
// state | meaning
// RUN   | normal issue; stall vector follows the highest stalling stage
// DRAIN | exception accepted, whole pipe frozen until dcache goes idle
// FLUSH | one-cycle redirect: flush=1, new_pc/flush_cause valid
module pipe_ctrl #(
    parameter int STALL_W = 7,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               exc_req,
    input  logic [31:0]        exc_target,
    input  logic               mispredict,
    input  logic [31:0]        mispredict_target,
    input  logic               mem_busy,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               flush_cause,
    output logic [31:0]        new_pc,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_count
);

    typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

    localparam logic [STALL_W-1:0] STALL_MEM = STALL_W'(7'b0011111);
    localparam logic [STALL_W-1:0] STALL_EX  = STALL_W'(7'b0001111);
    localparam logic [STALL_W-1:0] STALL_ID  = STALL_W'(7'b0000111);
    localparam logic [STALL_W-1:0] STALL_IF  = STALL_W'(7'b0000011);

    state_t             state_q, state_d;
    logic [31:0]        pend_pc_q, pend_pc_d;
    logic               pend_cause_q, pend_cause_d;
    logic [31:0]        new_pc_q, new_pc_d;
    logic               flush_cause_q, flush_cause_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;

    always_comb begin
        stall = '0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (stallreq_mem)     stall = STALL_MEM;
                    else if (stallreq_ex) stall = STALL_EX;
                    else if (stallreq_id) stall = STALL_ID;
                    else if (stallreq_if) stall = STALL_IF;
                end
                DRAIN:   stall = '1;
                default: stall = '0;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_pc_d     = pend_pc_q;
        pend_cause_d  = pend_cause_q;
        new_pc_d      = new_pc_q;
        flush_cause_d = flush_cause_q;
        case (state_q)
            RUN: begin
                if (exc_req) begin
                    if (mem_busy) begin
                        state_d      = DRAIN;
                        pend_pc_d    = exc_target;
                        pend_cause_d = 1'b0;
                    end else begin
                        state_d       = FLUSH;
                        new_pc_d      = exc_target;
                        flush_cause_d = 1'b0;
                    end
                end else if (mispredict && !stall[3]) begin
                    // A mispredict under an EX/MEM stall stays in EX and re-raises later.
                    state_d       = FLUSH;
                    new_pc_d      = mispredict_target;
                    flush_cause_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!mem_busy) begin
                    state_d       = FLUSH;
                    new_pc_d      = pend_pc_q;
                    flush_cause_d = pend_cause_q;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall[0] && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + 1'b1;
        if (state_q == FLUSH && flush_count_q != '1)
            flush_count_d = flush_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            pend_pc_q      <= '0;
            pend_cause_q   <= 1'b0;
            new_pc_q       <= '0;
            flush_cause_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            pend_pc_q      <= pend_pc_d;
            pend_cause_q   <= pend_cause_d;
            new_pc_q       <= new_pc_d;
            flush_cause_q  <= flush_cause_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign flush        = (state_q == FLUSH);
    assign flush_cause  = flush_cause_q;
    assign new_pc       = new_pc_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: stall-priority table, directed redirect/drain/reset
// sequences, and a randomized run against a behavioural reference model.
module tb_pipe_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic              exc_req, mispredict, mem_busy;
    logic [31:0]       exc_target, mispredict_target;
    logic [6:0]        stall;
    logic              flush, flush_cause;
    logic [31:0]       new_pc;
    logic [CNT_W-1:0]  stall_cycles, flush_count;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(.STALL_W(7), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .exc_req(exc_req), .exc_target(exc_target),
        .mispredict(mispredict), .mispredict_target(mispredict_target),
        .mem_busy(mem_busy),
        .stall(stall), .flush(flush), .flush_cause(flush_cause), .new_pc(new_pc),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;   // {mem, ex, id, if}
        logic [6:0] exp;
    } vec_t;
    vec_t vecs[8];

    // Reference model state
    bit          m_wait, m_redirect;
    logic [31:0] m_pend, m_pc;
    bit          m_cause;
    int          m_sc, m_fc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        exc_req = 0; mispredict = 0; mem_busy = 0;
        exc_target = '0; mispredict_target = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    // Number of low stall bits set = deepest stalled stage + 1 (PC bit included).
    function automatic logic [6:0] model_stall(input bit r, input bit wt, input bit rd,
                                               input bit sif, input bit sid, input bit sex,
                                               input bit smem);
        int n;
        if (r || rd) return 7'h00;
        if (wt) return 7'h7F;
        n = smem ? 5 : sex ? 4 : sid ? 3 : sif ? 2 : 0;
        return 7'((1 << n) - 1);
    endfunction

    task automatic model_edge();
        logic [6:0] s;
        s = model_stall(rst, m_wait, m_redirect, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        if (rst) begin
            m_wait = 0; m_redirect = 0; m_pend = '0; m_pc = '0; m_cause = 0; m_sc = 0; m_fc = 0;
            return;
        end
        if (s[0]) m_sc = (m_sc + 1 > CNT_MAX) ? CNT_MAX : m_sc + 1;
        if (m_redirect) begin
            m_fc = (m_fc + 1 > CNT_MAX) ? CNT_MAX : m_fc + 1;
            m_redirect = 0;
        end else if (m_wait) begin
            if (!mem_busy) begin
                m_wait = 0; m_redirect = 1; m_pc = m_pend; m_cause = 0;
            end
        end else if (exc_req) begin
            if (mem_busy) begin
                m_wait = 1; m_pend = exc_target;
            end else begin
                m_redirect = 1; m_pc = exc_target; m_cause = 0;
            end
        end else if (mispredict && !(stallreq_mem || stallreq_ex)) begin
            m_redirect = 1; m_pc = mispredict_target; m_cause = 1;
        end
    endtask

    initial begin
        logic [CNT_W-1:0] fc0;

        vecs[0] = '{4'b0000, 7'b0000000};
        vecs[1] = '{4'b0001, 7'b0000011};
        vecs[2] = '{4'b0010, 7'b0000111};
        vecs[3] = '{4'b0011, 7'b0000111};
        vecs[4] = '{4'b0100, 7'b0001111};
        vecs[5] = '{4'b0111, 7'b0001111};
        vecs[6] = '{4'b1000, 7'b0011111};
        vecs[7] = '{4'b1111, 7'b0011111};

        clear_inputs();
        rst = 1;
        stallreq_mem = 1;
        tick();
        tick();
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_new_pc", new_pc, 32'h0);
        check("rst_stall_cycles", 32'(stall_cycles), 32'h0);
        check("rst_flush_count", 32'(flush_count), 32'h0);
        stallreq_mem = 0;
        rst = 0;

        // IF-only stall for three cycles
        stallreq_if = 1;
        for (int i = 0; i < 3; i++) begin
            check("if_stall", 32'(stall), 32'h03);
            check("if_noflush", 32'(flush), 32'h0);
            tick();
        end
        stallreq_if = 0;
        check("if_stall_cycles", 32'(stall_cycles), 32'd3);

        for (int i = 0; i < 8; i++) begin
            {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = vecs[i].req;
            #1;
            check($sformatf("table_%0d", i), 32'(stall), 32'(vecs[i].exp));
        end
        clear_inputs();

        stallreq_id = 1; stallreq_mem = 1;
        #1;
        check("id_mem_stall", 32'(stall), 32'h1F);
        stallreq_mem = 0;
        #1;
        check("id_only_stall", 32'(stall), 32'h07);
        clear_inputs();

        // Mispredict redirect, then a mispredict masked by an EX stall
        mispredict = 1; mispredict_target = 32'h8000_0040;
        tick();
        mispredict = 0;
        check("mp_flush", 32'(flush), 32'h1);
        check("mp_cause", 32'(flush_cause), 32'h1);
        check("mp_new_pc", new_pc, 32'h8000_0040);
        tick();
        check("mp_flush_done", 32'(flush), 32'h0);
        mispredict = 1; mispredict_target = 32'h1234_5678; stallreq_ex = 1;
        tick();
        check("mp_masked", 32'(flush), 32'h0);
        clear_inputs();
        tick();

        // Exception held in DRAIN while dcache busy
        do_reset();
        exc_req = 1; exc_target = 32'hBFC0_0380; mem_busy = 1;
        tick();
        exc_req = 0; stallreq_if = 1; mispredict = 1; mispredict_target = 32'hDEAD_0000;
        for (int i = 0; i < 4; i++) begin
            check("drain_stall", 32'(stall), 32'h7F);
            check("drain_noflush", 32'(flush), 32'h0);
            tick();
        end
        mem_busy = 0;
        check("drain_last_stall", 32'(stall), 32'h7F);
        tick();
        clear_inputs();
        check("exc_flush", 32'(flush), 32'h1);
        check("exc_cause", 32'(flush_cause), 32'h0);
        check("exc_new_pc", new_pc, 32'hBFC0_0380);
        check("exc_stall", 32'(stall), 32'h0);
        tick();
        check("exc_flush_count", 32'(flush_count), 32'd1);
        check("exc_flush_done", 32'(flush), 32'h0);

        // Simultaneous exception + mispredict; mispredict during FLUSH is ignored
        exc_req = 1; exc_target = 32'h0000_0180;
        mispredict = 1; mispredict_target = 32'h0000_0abc;
        tick();
        exc_req = 0; mispredict_target = 32'h0000_0def;
        check("both_flush", 32'(flush), 32'h1);
        check("both_cause", 32'(flush_cause), 32'h0);
        check("both_new_pc", new_pc, 32'h0000_0180);
        tick();
        mispredict = 0;
        check("both_single_flush", 32'(flush), 32'h0);
        check("both_pc_hold", new_pc, 32'h0000_0180);
        tick();
        check("both_no_second", 32'(flush), 32'h0);

        // Reset in the middle of DRAIN discards the pending exception
        exc_req = 1; exc_target = 32'h0BAD_0000; mem_busy = 1;
        tick();
        exc_req = 0;
        check("pre_rst_drain", 32'(stall), 32'h7F);
        rst = 1;
        tick();
        check("rst_drain_stall", 32'(stall), 32'h0);
        check("rst_drain_flush", 32'(flush), 32'h0);
        check("rst_drain_sc", 32'(stall_cycles), 32'h0);
        check("rst_drain_fc", 32'(flush_count), 32'h0);
        rst = 0; mem_busy = 0;
        tick();
        check("rst_drain_noflush1", 32'(flush), 32'h0);
        tick();
        check("rst_drain_noflush2", 32'(flush), 32'h0);

        // Saturation of the stall counter
        stallreq_ex = 1;
        for (int i = 0; i < 20; i++) tick();
        stallreq_ex = 0;
        check("stall_sat", 32'(stall_cycles), 32'(CNT_MAX));
        fc0 = flush_count;
        check("sat_fc_unchanged", 32'(fc0), 32'h0);

        // Randomized run against the reference model
        clear_inputs();
        rst = 1;
        tick();
        model_edge();
        rst = 0;
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 59) == 0);
            stallreq_if  = ($urandom_range(0, 3) == 0);
            stallreq_id  = ($urandom_range(0, 4) == 0);
            stallreq_ex  = ($urandom_range(0, 5) == 0);
            stallreq_mem = ($urandom_range(0, 6) == 0);
            exc_req      = ($urandom_range(0, 9) == 0);
            mispredict   = ($urandom_range(0, 4) == 0);
            mem_busy     = ($urandom_range(0, 2) != 0);
            exc_target        = $urandom;
            mispredict_target = $urandom;
            #1;
            check("rnd_stall", 32'(stall),
                  32'(model_stall(rst, m_wait, m_redirect, stallreq_if, stallreq_id,
                                  stallreq_ex, stallreq_mem)));
            check("rnd_flush", 32'(flush), 32'(m_redirect));
            check("rnd_new_pc", new_pc, m_pc);
            check("rnd_cause", 32'(flush_cause), 32'(m_cause));
            check("rnd_stall_cycles", 32'(stall_cycles), 32'(m_sc));
            check("rnd_flush_count", 32'(flush_count), 32'(m_fc));
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
